// File: rtl/alu_exec_if.sv
// Bundles the execute-stage operand, control and result signals of alu_exec_unit.
// Ports (via modports):
//   master : drives aluop1/aluop0, funct, a, b, pc, br_offset, status_we;
//            observes gout, result, zero, status, status_q, pc_plus4, br_target.
//   slave  : the execute unit; sees the opposite directions.
interface alu_exec_if;
  logic        aluop1;
  logic        aluop0;
  logic [4:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic [31:0] br_offset;
  logic        status_we;

  logic [2:0]  gout;
  logic [31:0] result;
  logic        zero;
  logic [2:0]  status;
  logic [2:0]  status_q;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;

  modport master (
    output aluop1, aluop0, funct, a, b, pc, br_offset, status_we,
    input  gout, result, zero, status, status_q, pc_plus4, br_target
  );

  modport slave (
    input  aluop1, aluop0, funct, a, b, pc, br_offset, status_we,
    output gout, result, zero, status, status_q, pc_plus4, br_target
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage arithmetic block: ALU-control decode, 32-bit ALU with {Z,N,V} flags,
// PC+4 and branch-target adders, and a single 3-bit registered status.
// Ports:
//   clk   : clock, status register samples on rising edge
//   rst_n : asynchronous active-low reset, clears status_q only
//   bus   : alu_exec_if.slave carrying operands, control and results
module alu_exec_unit (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);

  logic [2:0]  gout;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] result;
  logic        ovf;
  logic [2:0]  status_d;
  logic [2:0]  status_q;

  // ALU control decode
  always_comb begin
    gout = 3'b010;
    unique case ({bus.aluop1, bus.aluop0})
      2'b00: gout = 3'b010;
      2'b01: gout = 3'b110;
      2'b11: gout = 3'b100;
      2'b10: begin
        case (bus.funct)
          5'b00000: gout = 3'b010;
          5'b00010: gout = 3'b110;
          5'b00100: gout = 3'b000;
          5'b00101: gout = 3'b001;
          5'b00111: gout = 3'b011;
          5'b01010: gout = 3'b111;
          default:  gout = 3'b010;
        endcase
      end
      default: gout = 3'b010;
    endcase
  end

  assign sum  = bus.a + bus.b;
  assign diff = bus.a - bus.b;

  always_comb begin
    result = 32'd0;
    ovf    = 1'b0;
    case (gout)
      3'b000: result = bus.a & bus.b;
      3'b001: result = bus.a | bus.b;
      3'b010: begin
        result = sum;
        ovf    = (bus.a[31] == bus.b[31]) && (sum[31] != bus.a[31]);
      end
      3'b110: begin
        result = diff;
        ovf    = (bus.a[31] != bus.b[31]) && (diff[31] != bus.a[31]);
      end
      3'b011: result = ~(bus.a | bus.b);
      3'b100: result = ~(bus.a & bus.b);
      // Direct signed compare, so the answer stays right when a-b overflows
      3'b111: result = {31'd0, ($signed(bus.a) < $signed(bus.b))};
      default: result = 32'd0;
    endcase
  end

  assign status_d = {(result == 32'd0), result[31], ovf};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 3'b000;
    end else if (bus.status_we) begin
      status_q <= status_d;
    end
  end

  assign bus.gout      = gout;
  assign bus.result    = result;
  assign bus.zero      = status_d[2];
  assign bus.status    = status_d;
  assign bus.status_q  = status_q;
  assign bus.pc_plus4  = bus.pc + 32'd4;
  assign bus.br_target = bus.pc + 32'd4 + bus.br_offset;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  logic [2:0] exp_sq;

  alu_exec_if bus ();

  alu_exec_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model from the operation tables, using wide signed arithmetic for V/slt
  function automatic void model(input logic op1, input logic op0, input logic [4:0] f,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [2:0] g, output logic [31:0] r,
                                output logic [2:0] st);
    longint sa, sb, wide;
    logic   v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v  = 1'b0;
    if (!op1 && !op0)     g = 3'b010;
    else if (!op1 && op0) g = 3'b110;
    else if (op1 && op0)  g = 3'b100;
    else if (f == 5'd0)   g = 3'b010;
    else if (f == 5'd2)   g = 3'b110;
    else if (f == 5'd4)   g = 3'b000;
    else if (f == 5'd5)   g = 3'b001;
    else if (f == 5'd7)   g = 3'b011;
    else if (f == 5'd10)  g = 3'b111;
    else                  g = 3'b010;
    r = 32'd0;
    if (g == 3'b000) r = a & b;
    if (g == 3'b001) r = a | b;
    if (g == 3'b011) r = ~(a | b);
    if (g == 3'b100) r = ~(a & b);
    if (g == 3'b111) r = (sa < sb) ? 32'd1 : 32'd0;
    if (g == 3'b010 || g == 3'b110) begin
      wide = (g == 3'b010) ? sa + sb : sa - sb;
      r    = wide[31:0];
      v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
    end
    st = {(r == 32'd0), r[31], v};
  endfunction

  task automatic drive(input logic [1:0] op, input logic [4:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    bus.aluop1 = op[1];
    bus.aluop0 = op[0];
    bus.funct  = f;
    bus.a      = a;
    bus.b      = b;
    #1;
  endtask

  task automatic check_comb(input string tag);
    logic [2:0]  g, st;
    logic [31:0] r;
    model(bus.aluop1, bus.aluop0, bus.funct, bus.a, bus.b, g, r, st);
    check({tag, ".gout"}, {29'd0, bus.gout}, {29'd0, g});
    check({tag, ".result"}, bus.result, r);
    check({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, st[2]});
    check({tag, ".status"}, {29'd0, bus.status}, {29'd0, st});
    check({tag, ".pc_plus4"}, bus.pc_plus4, bus.pc + 32'd4);
    check({tag, ".br_target"}, bus.br_target, bus.pc + 32'd4 + bus.br_offset);
  endtask

  // Called just after a negedge; crosses one rising edge and checks the register
  task automatic tick(input string tag);
    logic [2:0]  g, st;
    logic [31:0] r;
    model(bus.aluop1, bus.aluop0, bus.funct, bus.a, bus.b, g, r, st);
    if (bus.status_we && rst_n) exp_sq = st;
    @(posedge clk);
    #1;
    check(tag, {29'd0, bus.status_q}, {29'd0, exp_sq});
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    exp_sq        = 3'b000;
    bus.status_we = 1'b0;
    bus.pc        = 32'h0;
    bus.br_offset = 32'h0;
    drive(2'b00, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    check("reset.status_q", {29'd0, bus.status_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Add overflow into sign bit, then load it
    drive(2'b10, 5'b00000, 32'h7FFFFFFF, 32'h1);
    check("add_ovf.gout", {29'd0, bus.gout}, 32'd2);
    check("add_ovf.result", bus.result, 32'h80000000);
    check("add_ovf.status", {29'd0, bus.status}, 32'd3);
    bus.status_we = 1'b1;
    tick("add_ovf.status_q");
    check("add_ovf.status_q_const", {29'd0, bus.status_q}, 32'd3);

    // Sub to zero, write disabled: register holds
    bus.status_we = 1'b0;
    drive(2'b01, 5'd0, 32'd5, 32'd5);
    check("sub0.gout", {29'd0, bus.gout}, 32'd6);
    check("sub0.result", bus.result, 32'd0);
    check("sub0.zero", {31'd0, bus.zero}, 32'd1);
    check("sub0.status", {29'd0, bus.status}, 32'd4);
    tick("sub0.hold");
    check("sub0.hold_const", {29'd0, bus.status_q}, 32'd3);

    // slt across overflow
    drive(2'b10, 5'b01010, 32'h80000000, 32'h1);
    check("slt1.result", bus.result, 32'd1);
    check("slt1.v", {31'd0, bus.status[0]}, 32'd0);
    drive(2'b10, 5'b01010, 32'h1, 32'hFFFFFFFF);
    check("slt0.result", bus.result, 32'd0);
    check("slt0.v", {31'd0, bus.status[0]}, 32'd0);

    // Logic ops and unlisted funct
    drive(2'b10, 5'b00100, 32'hF0F0F0F0, 32'hFF00FF00);
    check("and.result", bus.result, 32'hF000F000);
    drive(2'b10, 5'b00101, 32'hF0F0F0F0, 32'hFF00FF00);
    check("or.result", bus.result, 32'hFFF0FFF0);
    drive(2'b10, 5'b00111, 32'hF0F0F0F0, 32'hFF00FF00);
    check("nor.result", bus.result, 32'h000F000F);
    drive(2'b11, 5'b00000, 32'hF0F0F0F0, 32'hFF00FF00);
    check("nand.result", bus.result, 32'h0FFF0FFF);
    drive(2'b10, 5'b11111, 32'hF0F0F0F0, 32'hFF00FF00);
    check("dflt.gout", {29'd0, bus.gout}, 32'd2);
    check("dflt.result", bus.result, 32'hEFF1EFF0);

    // PC adders
    bus.pc = 32'h10;
    bus.br_offset = 32'hFFFFFFF0;
    #1;
    check("pc.plus4", bus.pc_plus4, 32'h14);
    check("pc.br_back", bus.br_target, 32'h4);
    bus.pc = 32'hFFFFFFFC;
    #1;
    check("pc.wrap", bus.pc_plus4, 32'h0);

    // Load 100, asynchronous clear between edges, coincident release
    bus.status_we = 1'b1;
    drive(2'b01, 5'd0, 32'd9, 32'd9);
    tick("rst.load100");
    check("rst.load100_const", {29'd0, bus.status_q}, 32'd4);
    #2;
    rst_n = 1'b0;
    exp_sq = 3'b000;
    #1;
    check("rst.async_clear", {29'd0, bus.status_q}, 32'd0);
    check("rst.comb_alive", bus.result, 32'd0);
    drive(2'b10, 5'b00000, 32'h7FFFFFFF, 32'h1);
    check("rst.comb_track", bus.result, 32'h80000000);
    @(posedge clk);
    rst_n <= 1'b1;  // released in the same step as the edge
    #1;
    check("rst.release_edge", {29'd0, bus.status_q}, 32'd0);
    @(negedge clk);
    tick("rst.first_load");
    check("rst.first_load_const", {29'd0, bus.status_q}, 32'd3);

    // Randomised sweep against the model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      logic [4:0]  rf;
      int          pick;
      pick = $urandom_range(0, 9);
      ra = $urandom;
      rb = $urandom;
      if (pick == 0) ra = 32'h7FFFFFFF;
      if (pick == 1) rb = 32'h80000000;
      if (pick == 2) rb = ra;
      case ($urandom_range(0, 7))
        0: rf = 5'd0;
        1: rf = 5'd2;
        2: rf = 5'd4;
        3: rf = 5'd5;
        4: rf = 5'd7;
        5: rf = 5'd10;
        default: rf = 5'($urandom);
      endcase
      bus.pc        = $urandom;
      bus.br_offset = $urandom;
      bus.status_we = 1'($urandom);
      drive(2'($urandom), rf, ra, rb);
      check_comb($sformatf("rnd%0d", i));
      if (i % 4 == 0) tick($sformatf("rnd%0d.status_q", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
